// File: rtl/occupancy_decoder_if.sv
// occupancy_decoder_if
// Bundles the sensor pair and the decoded occupancy outputs of the gate
// receiver so the decoder and its environment share one connection.
//   btn          sensor pair, btn[0]=a (outer), btn[1]=b (inner), asynchronous
//   count        current occupancy
//   debug_state  decoder state encoding
//   inc_pulse    1-cycle pulse, entry accepted
//   dec_pulse    1-cycle pulse, exit accepted
//   err_pulse    1-cycle pulse, invalid transition or count boundary hit
//   full         count at saturation ceiling
//   empty        count at zero
// master: sensor/display side (drives btn). slave: the decoder.
interface occupancy_decoder_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       btn;
  logic [WIDTH-1:0] count;
  logic [2:0]       debug_state;
  logic             inc_pulse;
  logic             dec_pulse;
  logic             err_pulse;
  logic             full;
  logic             empty;

  modport master (
    output btn,
    input  count, debug_state, inc_pulse, dec_pulse, err_pulse, full, empty
  );

  modport slave (
    input  btn,
    output count, debug_state, inc_pulse, dec_pulse, err_pulse, full, empty
  );
endinterface

// File: rtl/occupancy_decoder.sv
// occupancy_decoder
// Receive end of the two-sensor (a,b) gate protocol. Synchronises and
// debounces the sensor pair, decodes complete entry/exit sequences into a
// saturating occupancy count and flags malformed sequences.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    occupancy_decoder_if.slave (btn in; count, debug_state, pulses,
//          full, empty out)
//
// state  | meaning
// IDLE   | no sequence in progress, filt = 00
// EN1    | entry started, a blocked (01)
// EN2    | entry, both blocked (11)
// EN3    | entry, only b blocked (10)
// EX1    | exit started, b blocked (10)
// EX2    | exit, both blocked (11)
// EX3    | exit, only a blocked (01)
// ERR    | malformed sequence, waiting for both sensors clear
module occupancy_decoder #(
  parameter int WIDTH           = 4,
  parameter int MAX_COUNT       = 15,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic               clk,
  input logic               reset,
  occupancy_decoder_if.slave bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MAX_COUNT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EN1  = 3'd1,
    S_EN2  = 3'd2,
    S_EN3  = 3'd3,
    S_EX1  = 3'd4,
    S_EX2  = 3'd5,
    S_EX3  = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [DB_W-1:0]  r_db_cnt;
  logic [1:0]       r_filt;
  logic [1:0]       r_filt_q;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_inc;
  logic             r_dec;
  logic             r_err;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_inc_nxt;
  logic             w_dec_nxt;
  logic             w_err_nxt;
  logic             w_chg;
  logic             w_dbl;

  // Input path. A difference between the two sync stages means r_sync2 is
  // about to take a new value, so the stability timer is reloaded on that
  // same edge; it then reaches zero after DEBOUNCE_CYCLES cycles of the new
  // value and filt samples it on the following edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 2'b00;
      r_sync2  <= 2'b00;
      r_db_cnt <= '0;
      r_filt   <= 2'b00;
      r_filt_q <= 2'b00;
    end else begin
      r_sync1  <= bus.btn;
      r_sync2  <= r_sync1;
      r_filt_q <= r_filt;
      if (r_sync1 != r_sync2) begin
        r_db_cnt <= DB_LOAD;
      end else if (r_db_cnt != '0) begin
        r_db_cnt <= r_db_cnt - 1'b1;
      end
      if (r_db_cnt == '0) begin
        r_filt <= r_sync2;
      end
    end
  end

  assign w_chg = (r_filt != r_filt_q);
  assign w_dbl = ((r_filt ^ r_filt_q) == 2'b11);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_inc   <= w_inc_nxt;
      r_dec   <= w_dec_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_inc_nxt   = 1'b0;
    w_dec_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    if (r_state == S_ERR) begin
      // Level-sensitive release: an abort that itself lands on 00 (e.g.
      // 11->00) leaves ERR on the next cycle instead of waiting for another
      // filt change that may never come.
      if (r_filt == 2'b00) begin
        w_state_nxt = S_IDLE;
      end
    end else if (w_chg) begin
      if (w_dbl) begin
        w_state_nxt = S_ERR;
        w_err_nxt   = 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_filt == 2'b01)      w_state_nxt = S_EN1;
            else if (r_filt == 2'b10) w_state_nxt = S_EX1;
          end
          S_EN1: begin
            if (r_filt == 2'b11)      w_state_nxt = S_EN2;
            else if (r_filt == 2'b00) w_state_nxt = S_IDLE;
          end
          S_EN2: begin
            if (r_filt == 2'b10)      w_state_nxt = S_EN3;
            else if (r_filt == 2'b01) w_state_nxt = S_EN1;
          end
          S_EN3: begin
            if (r_filt == 2'b00) begin
              w_state_nxt = S_IDLE;
              if (r_count < CNT_MAX) begin
                w_count_nxt = r_count + 1'b1;
                w_inc_nxt   = 1'b1;
              end else begin
                w_err_nxt   = 1'b1;
              end
            end else if (r_filt == 2'b11) begin
              w_state_nxt = S_EN2;
            end
          end
          S_EX1: begin
            if (r_filt == 2'b11)      w_state_nxt = S_EX2;
            else if (r_filt == 2'b00) w_state_nxt = S_IDLE;
          end
          S_EX2: begin
            if (r_filt == 2'b01)      w_state_nxt = S_EX3;
            else if (r_filt == 2'b10) w_state_nxt = S_EX1;
          end
          S_EX3: begin
            if (r_filt == 2'b00) begin
              w_state_nxt = S_IDLE;
              if (r_count != '0) begin
                w_count_nxt = r_count - 1'b1;
                w_dec_nxt   = 1'b1;
              end else begin
                w_err_nxt   = 1'b1;
              end
            end else if (r_filt == 2'b11) begin
              w_state_nxt = S_EX2;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.count       = r_count;
  assign bus.debug_state = r_state;
  assign bus.inc_pulse   = r_inc;
  assign bus.dec_pulse   = r_dec;
  assign bus.err_pulse   = r_err;
  assign bus.full        = (r_count == CNT_MAX);
  assign bus.empty       = (r_count == '0);

endmodule

// File: tb/tb_occupancy_decoder.sv
module tb_occupancy_decoder;
  localparam int WIDTH = 4;
  localparam int MAXC  = 15;
  localparam int DB    = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  occupancy_decoder_if #(.WIDTH(WIDTH)) u_if ();

  occupancy_decoder #(
    .WIDTH(WIDTH), .MAX_COUNT(MAXC), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .reset(reset), .bus(u_if.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int pc_inc = 0, pc_dec = 0, pc_err = 0;
  logic [7:0] seen = '0;
  logic prev_pulse = 1'b0;

  // pulse monitor: counts pulses, records visited states, checks exclusivity
  always @(negedge clk) begin : mon
    int np;
    if (reset) begin
      np = 0;
      if (u_if.inc_pulse) begin pc_inc++; np++; end
      if (u_if.dec_pulse) begin pc_dec++; np++; end
      if (u_if.err_pulse) begin pc_err++; np++; end
      seen[u_if.debug_state] = 1'b1;
      if (np != 0) begin
        n_vec++;
        if (np > 1 || prev_pulse) begin
          n_err++;
          $display("FAIL pulse_excl: %0d pulses, previous cycle pulse=%0b; required one pulse, none previous", np, prev_pulse);
        end
      end
      prev_pulse = (np != 0);
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic clr();
    pc_inc = 0; pc_dec = 0; pc_err = 0; seen = '0;
  endtask

  task automatic step(input logic [1:0] v, input int n);
    clr();
    u_if.btn = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_all(input string tag, input int cnt, input int st,
                           input int inc, input int dec, input int err);
    chk({tag, ".count"}, int'(u_if.count), cnt);
    chk({tag, ".state"}, int'(u_if.debug_state), st);
    chk({tag, ".inc"}, pc_inc, inc);
    chk({tag, ".dec"}, pc_dec, dec);
    chk({tag, ".err"}, pc_err, err);
    chk({tag, ".full"}, int'(u_if.full), (cnt == MAXC) ? 1 : 0);
    chk({tag, ".empty"}, int'(u_if.empty), (cnt == 0) ? 1 : 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    u_if.btn = 2'b00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic entry_seq(input int n);
    step(2'b01, n); step(2'b11, n); step(2'b10, n); step(2'b00, n);
  endtask

  task automatic exit_seq(input int n);
    step(2'b10, n); step(2'b11, n); step(2'b01, n); step(2'b00, n);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0] ab;
    int cnt, st, inc, dec, err, saw;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic [1:0] ab, input int cnt, input int st,
                              input int inc, input int dec, input int err, input int saw);
    vec_t r;
    r.ab = ab; r.cnt = cnt; r.st = st; r.inc = inc; r.dec = dec; r.err = err; r.saw = saw;
    tbl.push_back(r);
  endfunction

  function automatic void add_entry(input int c);
    add(2'b01, c, 1, 0, 0, 0, 0);
    add(2'b11, c, 2, 0, 0, 0, 0);
    add(2'b10, c, 3, 0, 0, 0, 0);
    add(2'b00, c + 1, 0, 1, 0, 0, 0);
  endfunction

  function automatic void add_exit(input int c);
    add(2'b10, c, 4, 0, 0, 0, 0);
    add(2'b11, c, 5, 0, 0, 0, 0);
    add(2'b01, c, 6, 0, 0, 0, 0);
    add(2'b00, c - 1, 0, 0, 1, 0, 0);
  endfunction

  // ---------------- reference model ----------------
  // Tracks progress along the entry/exit sensor paths as a depth index.
  logic [1:0] ent_p[5];
  logic [1:0] ext_p[5];
  int   m_cnt, m_dir, m_d;   // m_dir: 0 none, 1 entry, 2 exit
  logic m_err;
  logic [1:0] m_prev;

  function automatic logic [1:0] path_at(input int dir, input int idx);
    return (dir == 1) ? ent_p[idx] : ext_p[idx];
  endfunction

  task automatic model_step(input logic [1:0] v, output int ei, output int ed, output int ee);
    ei = 0; ed = 0; ee = 0;
    if (v != m_prev) begin
      if (m_err) begin
        if (v == 2'b00) m_err = 1'b0;
      end else if ($countones(v ^ m_prev) == 2) begin
        m_err = 1'b1; ee = 1; m_dir = 0; m_d = 0;
        if (v == 2'b00) m_err = 1'b0;
      end else if (m_dir == 0) begin
        if (v == 2'b01) begin m_dir = 1; m_d = 1; end
        else if (v == 2'b10) begin m_dir = 2; m_d = 1; end
      end else begin
        if (v == path_at(m_dir, m_d + 1)) m_d++;
        else if (v == path_at(m_dir, m_d - 1)) m_d--;
        if (m_d == 4) begin
          if (m_dir == 1) begin
            if (m_cnt < MAXC) begin m_cnt++; ei = 1; end else ee = 1;
          end else begin
            if (m_cnt > 0) begin m_cnt--; ed = 1; end else ee = 1;
          end
          m_d = 0;
        end
        if (m_d == 0) m_dir = 0;
      end
      m_prev = v;
    end
  endtask

  function automatic int model_state();
    if (m_err) return 7;
    if (m_dir == 1) return m_d;
    if (m_dir == 2) return 3 + m_d;
    return 0;
  endfunction

  initial begin
    ent_p[0] = 2'b00; ent_p[1] = 2'b01; ent_p[2] = 2'b11; ent_p[3] = 2'b10; ent_p[4] = 2'b00;
    ext_p[0] = 2'b00; ext_p[1] = 2'b10; ext_p[2] = 2'b11; ext_p[3] = 2'b01; ext_p[4] = 2'b00;

    // three entries, three exits
    add_entry(0); add_entry(1); add_entry(2);
    add_exit(3); add_exit(2); add_exit(1);
    // single entry
    add_entry(0);
    // entry aborted at each depth, count stays 1
    add(2'b11, 1, 7, 0, 0, 1, 1); add(2'b00, 1, 0, 0, 0, 0, 1);
    add(2'b01, 1, 1, 0, 0, 0, 0); add(2'b10, 1, 7, 0, 0, 1, 1); add(2'b00, 1, 0, 0, 0, 0, 1);
    add(2'b01, 1, 1, 0, 0, 0, 0); add(2'b11, 1, 2, 0, 0, 0, 0); add(2'b00, 1, 0, 0, 0, 1, 1);
    // exit aborted at each depth
    add(2'b11, 1, 7, 0, 0, 1, 1); add(2'b00, 1, 0, 0, 0, 0, 1);
    add(2'b10, 1, 4, 0, 0, 0, 0); add(2'b01, 1, 7, 0, 0, 1, 1); add(2'b00, 1, 0, 0, 0, 0, 1);
    add(2'b10, 1, 4, 0, 0, 0, 0); add(2'b11, 1, 5, 0, 0, 0, 0); add(2'b00, 1, 0, 0, 0, 1, 1);
    // backing out at each depth
    add(2'b01, 1, 1, 0, 0, 0, 0); add(2'b11, 1, 2, 0, 0, 0, 0);
    add(2'b01, 1, 1, 0, 0, 0, 0); add(2'b00, 1, 0, 0, 0, 0, 0);
    add(2'b01, 1, 1, 0, 0, 0, 0); add(2'b11, 1, 2, 0, 0, 0, 0); add(2'b10, 1, 3, 0, 0, 0, 0);
    add(2'b11, 1, 2, 0, 0, 0, 0); add(2'b01, 1, 1, 0, 0, 0, 0); add(2'b00, 1, 0, 0, 0, 0, 0);
    add(2'b10, 1, 4, 0, 0, 0, 0); add(2'b11, 1, 5, 0, 0, 0, 0); add(2'b01, 1, 6, 0, 0, 0, 0);
    add(2'b11, 1, 5, 0, 0, 0, 0); add(2'b10, 1, 4, 0, 0, 0, 0); add(2'b00, 1, 0, 0, 0, 0, 0);
    add_exit(1);

    // reset state
    reset = 1'b0;
    u_if.btn = 2'b00;
    repeat (3) @(posedge clk);
    #2;
    chk("rst.count", int'(u_if.count), 0);
    chk("rst.state", int'(u_if.debug_state), 0);
    chk("rst.pulses", int'({u_if.inc_pulse, u_if.dec_pulse, u_if.err_pulse}), 0);
    chk("rst.full", int'(u_if.full), 0);
    chk("rst.empty", int'(u_if.empty), 1);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].ab, 100);
      check_all($sformatf("row%0d", i), tbl[i].cnt, tbl[i].st, tbl[i].inc, tbl[i].dec, tbl[i].err);
      chk($sformatf("row%0d.saw_err", i), int'(seen[7]), tbl[i].saw);
    end

    // latency: filt update 2+DB edges after change, state one edge later
    step(2'b01, 2 + DB);
    chk("lat.before", int'(u_if.debug_state), 0);
    step(2'b01, 1);
    chk("lat.at", int'(u_if.debug_state), 1);
    step(2'b00, 40);
    chk("lat.back", int'(u_if.debug_state), 0);

    // saturation up to MAX and one entry past it
    do_reset();
    for (int i = 0; i < MAXC; i++) begin
      entry_seq(30);
      chk($sformatf("sat%0d.count", i), int'(u_if.count), i + 1);
      chk($sformatf("sat%0d.inc", i), pc_inc, 1);
    end
    chk("sat.full", int'(u_if.full), 1);
    entry_seq(30);
    check_all("sat_over", MAXC, 0, 0, 0, 1);

    // asynchronous reset while in EN2
    step(2'b01, 30);
    step(2'b11, 30);
    chk("rst_en2.pre_state", int'(u_if.debug_state), 2);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_en2.count", int'(u_if.count), 0);
    chk("rst_en2.state", int'(u_if.debug_state), 0);
    chk("rst_en2.empty", int'(u_if.empty), 1);
    u_if.btn = 2'b00;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    step(2'b00, 40);
    check_all("rst_en2.after", 0, 0, 0, 0, 0);

    // exit at zero
    exit_seq(30);
    check_all("exit_zero", 0, 0, 0, 0, 1);

    // short glitch on a while idle
    clr();
    u_if.btn = 2'b01;
    repeat (5) @(posedge clk);
    u_if.btn = 2'b00;
    repeat (100) @(posedge clk);
    #2;
    chk("glitch.seen", int'(seen), 1);
    check_all("glitch", 0, 0, 0, 0, 0);

    // randomized walk against the model
    do_reset();
    m_cnt = 0; m_dir = 0; m_d = 0; m_err = 1'b0; m_prev = 2'b00;
    for (int k = 0; k < 250; k++) begin
      int r, ei, ed, ee;
      logic [1:0] v, flip;
      r = $urandom_range(0, 99);
      flip = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      if (r < 10)                                 v = m_prev ^ 2'b11;
      else if (r < 15)                            v = m_prev;
      else if (r < 60 && m_dir != 0 && !m_err)    v = path_at(m_dir, m_d + 1);
      else                                        v = m_prev ^ flip;
      model_step(v, ei, ed, ee);
      clr();
      u_if.btn = v;
      repeat (24) @(posedge clk);
      if ($urandom_range(0, 9) < 3) begin
        u_if.btn = v ^ flip;
        repeat ($urandom_range(1, 10)) @(posedge clk);
        u_if.btn = v;
        repeat (24) @(posedge clk);
      end
      #2;
      check_all($sformatf("rnd%0d", k), m_cnt, model_state(), ei, ed, ee);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
